// File: rtl/mem_access_stage.sv
// mem_access_stage
//   MEM pipeline stage with an integrated MEM/WB register. Accepts one
//   instruction at a time from execute (valid/ready), issues loads/stores on a
//   request/grant/response data-memory port with byte enables, extends
//   sub-word load data, and bounds load responses with a timeout.
//
//   Optional build macro: MEM_ACC_MISALIGN_TRAP_EN
//     defined   : misaligned memory ops bypass dmem and complete with
//                 wb_misaligned = 1, wb_reg_write = 0
//     undefined : low offset bits below the access size are dropped
//                 (access forced size-aligned); wb_misaligned reads 0
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   ex_*                       instruction from execute (valid/ready handshake)
//   condpc                     ex_cond ? ex_alu_result : ex_npc (combinational)
//   dmem_req/we/addr/wdata/be  memory request, held until dmem_gnt
//   dmem_gnt                   request accepted
//   dmem_rvalid/rdata          load response
//   wb_*                       MEM/WB register (valid/ready handshake)

module mem_access_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ex_valid,
    output logic                    ex_ready,
    input  logic [DATA_WIDTH-1:0]   ex_alu_result,
    input  logic [DATA_WIDTH-1:0]   ex_store_data,
    input  logic [DATA_WIDTH-1:0]   ex_npc,
    input  logic                    ex_cond,
    input  logic                    ex_mem_rd,
    input  logic                    ex_mem_wr,
    input  logic [1:0]              ex_size,
    input  logic                    ex_unsigned,
    input  logic                    ex_reg_write,
    input  logic                    ex_mem_to_reg,
    input  logic [4:0]              ex_rd,
    output logic [DATA_WIDTH-1:0]   condpc,
    output logic                    dmem_req,
    output logic                    dmem_we,
    input  logic                    dmem_gnt,
    output logic [DATA_WIDTH-1:0]   dmem_addr,
    output logic [DATA_WIDTH-1:0]   dmem_wdata,
    output logic [DATA_WIDTH/8-1:0] dmem_be,
    input  logic                    dmem_rvalid,
    input  logic [DATA_WIDTH-1:0]   dmem_rdata,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [DATA_WIDTH-1:0]   wb_lmd,
    output logic [DATA_WIDTH-1:0]   wb_alu_result,
    output logic [4:0]              wb_rd,
    output logic                    wb_reg_write,
    output logic                    wb_mem_to_reg,
    output logic                    wb_bus_err,
    output logic                    wb_misaligned
);
    localparam int BW   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(BW);
    localparam int CW   = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [BW-1:0] BE1  = BW'(1);
    localparam logic [BW-1:0] BE3  = BW'(3);
    localparam logic [BW-1:0] BE15 = BW'(15);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;
    state_t state_q, state_d;

    // Request registers, captured on accept
    logic [DATA_WIDTH-1:0] alu_q, wdata_q;
    logic [OFFW-1:0]       off_q;
    logic [1:0]            size_q;
    logic                  uns_q, we_q, rw_q, m2r_q;
    logic [4:0]            rd_q;
    logic [CW-1:0]         cnt_q, cnt_d;

    // MEM/WB register
    logic                  wb_valid_q, wb_rw_q, wb_m2r_q, wb_err_q, wb_mis_q;
    logic [DATA_WIDTH-1:0] wb_lmd_q, wb_alu_q;
    logic [4:0]            wb_rd_q;
    logic                  wb_load, wb_rw_d, wb_m2r_d, wb_err_d, wb_mis_d;
    logic [DATA_WIDTH-1:0] wb_lmd_d, wb_alu_d;
    logic [4:0]            wb_rd_d;

    logic                  accept, is_mem, trap;
    logic [OFFW-1:0]       raw_off, lo_mask, eff_off;
    logic [BW-1:0]         be;
    logic [DATA_WIDTH-1:0] rep, shifted, lmd;

    assign condpc   = ex_cond ? ex_alu_result : ex_npc;
    assign ex_ready = (state_q == IDLE) && (!wb_valid_q || wb_ready);
    assign accept   = ex_valid && ex_ready;
    assign is_mem   = ex_mem_rd | ex_mem_wr;

    // lo_mask selects the offset bits below the access size
    assign raw_off  = ex_alu_result[OFFW-1:0];
    assign lo_mask  = OFFW'((32'd1 << ex_size) - 32'd1);
    assign eff_off  = raw_off & ~lo_mask;

`ifdef MEM_ACC_MISALIGN_TRAP_EN
    assign trap = is_mem & (|(raw_off & lo_mask));
`else
    assign trap = 1'b0;
`endif

    // Byte lanes and replicated store data for the held request
    always_comb begin
        be  = '1;
        rep = wdata_q;
        case (size_q)
            2'd0: begin be = BE1  << off_q; rep = {BW{wdata_q[7:0]}};         end
            2'd1: begin be = BE3  << off_q; rep = {(BW/2){wdata_q[15:0]}};    end
            2'd2: begin be = BE15 << off_q; rep = {(BW/4){wdata_q[31:0]}};    end
            default: ;
        endcase
    end

    assign dmem_req   = (state_q == REQ);
    assign dmem_we    = dmem_req & we_q;
    assign dmem_be    = dmem_req ? be : '0;
    assign dmem_wdata = dmem_req ? rep : '0;
    assign dmem_addr  = dmem_req ? {alu_q[DATA_WIDTH-1:OFFW], {OFFW{1'b0}}} : '0;

    // Load data: align selected lanes to bit 0, then extend
    assign shifted = dmem_rdata >> {off_q, 3'b000};
    always_comb begin
        lmd = shifted;
        case (size_q)
            2'd0: lmd = DATA_WIDTH'({{56{~uns_q & shifted[7]}},  shifted[7:0]});
            2'd1: lmd = DATA_WIDTH'({{48{~uns_q & shifted[15]}}, shifted[15:0]});
            2'd2: lmd = DATA_WIDTH'({{32{~uns_q & shifted[31]}}, shifted[31:0]});
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wb_load  = 1'b0;
        wb_lmd_d = '0;
        wb_alu_d = alu_q;
        wb_rd_d  = rd_q;
        wb_rw_d  = rw_q;
        wb_m2r_d = m2r_q;
        wb_err_d = 1'b0;
        wb_mis_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_mem && !trap) begin
                        state_d = REQ;
                    end else begin
                        wb_load  = 1'b1;
                        wb_alu_d = ex_alu_result;
                        wb_rd_d  = ex_rd;
                        wb_rw_d  = ex_reg_write & ~trap;
                        wb_m2r_d = ex_mem_to_reg;
                        wb_mis_d = trap;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    if (we_q) begin
                        wb_load = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                cnt_d = cnt_q + CW'(1);
                if (dmem_rvalid) begin
                    wb_load  = 1'b1;
                    wb_lmd_d = lmd;
                    state_d  = IDLE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES))) begin
                    wb_load  = 1'b1;
                    wb_err_d = 1'b1;
                    wb_rw_d  = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            alu_q      <= '0;
            wdata_q    <= '0;
            off_q      <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            we_q       <= 1'b0;
            rw_q       <= 1'b0;
            m2r_q      <= 1'b0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_lmd_q   <= '0;
            wb_alu_q   <= '0;
            wb_rd_q    <= '0;
            wb_rw_q    <= 1'b0;
            wb_m2r_q   <= 1'b0;
            wb_err_q   <= 1'b0;
            wb_mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                alu_q   <= ex_alu_result;
                wdata_q <= ex_store_data;
                off_q   <= eff_off;
                size_q  <= ex_size;
                uns_q   <= ex_unsigned;
                we_q    <= ex_mem_wr & ~ex_mem_rd;
                rw_q    <= ex_reg_write;
                m2r_q   <= ex_mem_to_reg;
                rd_q    <= ex_rd;
            end
            if (wb_load) begin
                wb_valid_q <= 1'b1;
                wb_lmd_q   <= wb_lmd_d;
                wb_alu_q   <= wb_alu_d;
                wb_rd_q    <= wb_rd_d;
                wb_rw_q    <= wb_rw_d;
                wb_m2r_q   <= wb_m2r_d;
                wb_err_q   <= wb_err_d;
                wb_mis_q   <= wb_mis_d;
            end else if (wb_valid_q && wb_ready) begin
                wb_valid_q <= 1'b0;
            end
        end
    end

    assign wb_valid      = wb_valid_q;
    assign wb_lmd        = wb_lmd_q;
    assign wb_alu_result = wb_alu_q;
    assign wb_rd         = wb_rd_q;
    assign wb_reg_write  = wb_rw_q;
    assign wb_mem_to_reg = wb_m2r_q;
    assign wb_bus_err    = wb_err_q;
    assign wb_misaligned = wb_mis_q;

endmodule
